// File: rtl/uart_tx.sv
// UART transmitter: write FIFO feeding a start/data/parity/stop serialiser.
// Bit timing is set by the external clken pulse, one pulse per bit period.
//
// state  | meaning
// IDLE   | line high, waiting for clken with tx_en and a queued byte
// START  | start bit (0) on the line
// DATA   | eight data bits, LSB first
// PARITY | parity bit over the latched byte
// STOP   | STOP_BITS stop bits, then chain the next frame or go idle
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  input  logic       tx_en,
  input  logic       clken,
  output logic       Tx,
  output logic       tx_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [7:0]      shift;
  logic [7:0]      frame_byte;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;
  logic [7:0]      head;
  logic            push, pop, frame_end;

  assign head      = mem[rd_ptr];
  assign push      = wr_en && !full;
  // A pop happens only where the FSM starts a frame: from idle, or chained off the last stop bit.
  assign frame_end = (state == STOP) && (stop_cnt == STOP_LAST);
  assign pop       = clken && tx_en && !empty && ((state == IDLE) || frame_end);

  // Next occupancy; a simultaneous push and pop cancel.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= din;
  end

  // FIFO pointers, count and registered full/empty flags.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
    end
  end

  // Serialiser FSM; advances only on clken, otherwise holds state and line.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state      <= IDLE;
      Tx         <= 1'b1;
      tx_busy    <= 1'b0;
      shift      <= '0;
      frame_byte <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (pop) begin
            shift      <= head;
            frame_byte <= head;
            Tx         <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          Tx      <= shift[0];
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt != 3'd7) begin
            shift   <= shift >> 1;
            Tx      <= shift[1];
            bit_cnt <= bit_cnt + 3'd1;
          end else if (PARITY_EN != 0) begin
            Tx    <= (^frame_byte) ^ ODD;
            state <= PARITY;
          end else begin
            Tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        PARITY: begin
          Tx       <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= STOP;
        end
        STOP: begin
          if (frame_end) begin
            if (pop) begin
              // Chain straight into the next start bit with no idle gap.
              shift      <= head;
              frame_byte <= head;
              Tx         <= 1'b0;
              state      <= START;
            end else begin
              Tx      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            stop_cnt <= 1'b1;
            Tx       <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          Tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. Pairs with the 16x-oversampling UART receiver on the same link.
- Accepts bytes from the core through a small write FIFO and serialises them LSB-first: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Bit timing comes from an externally generated baud-rate enable pulse (clken). One clken = one bit period; no oversampling on the TX side.

Parameters:
- FIFO_DEPTH, 4, write-FIFO entries; power of 2, minimum 2.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_50m  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  byte to transmit.
- wr_en  input  1  push din into the FIFO this cycle.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- tx_en  input  1  transmitter enable; when low, no new frame starts.
- clken  input  1  baud enable, single-cycle pulse per bit period.
- Tx  output  1  serial line, idle high; registered.
- tx_busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst=1 at an edge):
  - Tx=1, tx_busy=0, full=0, empty=1.
  - FIFO pointers and count cleared; FSM to IDLE; shift register and bit counter cleared.
  - rst has priority over every other input. Reset mid-frame aborts the frame, and Tx=1 from the next edge. Queued bytes are discarded.
- FIFO:
  - Push occurs when wr_en && !full at an edge.
  - wr_en while full is dropped silently. This holds even if a pop happens in the same cycle, because full is evaluated before the edge.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - full and empty are registered and derived from count; they reflect the push/pop one cycle after the edge.
- FSM: IDLE, START, DATA, PARITY, STOP. The FSM advances only on edges where clken=1; otherwise it holds state and Tx.
  - IDLE:
    - Tx=1.
    - On clken && tx_en && !empty: pop the FIFO head into the shift register, Tx<=0, tx_busy<=1, go to START.
  - START:
    - On clken: Tx<=shift[0], bit_cnt<=0, go to DATA.
  - DATA:
    - On clken with bit_cnt<7: shift right, Tx<=next bit, bit_cnt++.
    - On clken with bit_cnt==7: go to PARITY (PARITY_EN=1) or STOP.
  - PARITY:
    - Tx = XOR of the 8 latched data bits, XOR PARITY_ODD.
    - Parity is computed from a copy latched at pop time.
  - STOP:
    - Tx=1 for STOP_BITS bit periods, counted with a stop counter.
    - At the clken ending the last stop bit: if tx_en && !empty, pop and go straight to START (Tx<=0, no idle gap, tx_busy stays 1). Otherwise go to IDLE with tx_busy<=0.
- Each bit occupies exactly one clken-to-clken interval on Tx.
- Frame length is 10, 11, or 12 bit periods depending on parameters.
- tx_en deasserted mid-frame: the current frame completes normally; the next frame is not started.
- clken held high continuously gives one bit per clk_50m cycle. This must work correctly.
- Latency: a push into an empty FIFO with tx_en=1 produces the start bit at the first clken at least one cycle after the push edge.
- The default-state branch returns to IDLE with Tx=1.

Test Plan:
- Reset, then single byte: push 0x55, tx_en=1, clken every 4 clocks, defaults → Tx shows 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop), each held 4 clocks. tx_busy high for 40 clocks, then 0. empty returns to 1 after the pop.
- Back-to-back with parity: PARITY_EN=1, PARITY_ODD=0; push 0xA3, then 0x0F → frame 1 data bits 1,1,0,0,0,1,0,1 with parity 0; frame 2 parity 0. The start bit of frame 2 immediately follows the stop bit of frame 1. tx_busy never drops between frames.
- FIFO full/overflow: tx_en=0, push 0x11, 0x22, 0x33, 0x44, 0x55 → full=1 after the 4th push, 0x55 dropped. Then tx_en=1 → exactly four frames, in order 0x11, 0x22, 0x33, 0x44. full drops after the first pop.
- Two stop bits with odd parity: STOP_BITS=2, PARITY_EN=1, PARITY_ODD=1, byte 0x00 → frame 0, 8×0, parity 1, 1, 1 (12 bit periods).
- Reset mid-frame: assert rst during data bit 3 of 0xF0 with 2 bytes queued → Tx=1 on the next edge; tx_busy=0, empty=1. With no new pushes, no further frames appear.
- tx_en gating and continuous clken: clken=1 constantly; push 0x81; drop tx_en during bit 2 → the frame completes at 1 bit/clock (0,1,0,0,0,0,0,0,1,1). A second queued byte waits until tx_en returns.
